// File: rtl/mcycle_unit.sv
// Multi-cycle unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Latency WIDTH+1 cycles from Start; Busy stalls decode, Start is ignored while computing.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE,
        COMPUTING
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_count;
    logic             r_op;
    logic [WIDTH-1:0] r_opnd2;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_rem;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_qbit;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH-1:0] w_rem_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_state_nxt = COMPUTING;
                    w_accept    = 1'b1;
                end
            end
            COMPUTING: begin
                if (r_count == CW'(WIDTH - 1)) begin
                    w_state_nxt = IDLE;
                    w_last      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        Busy = w_accept || (r_state == COMPUTING);
    end

    // lo doubles as the multiplier shift register and as the dividend/quotient
    // shift register; w_shift is the WIDTH+1-bit partial remainder of the divide.
    always_comb begin
        w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd2} : {(WIDTH+1){1'b0}});
        w_shift   = {r_rem, r_lo[WIDTH-1]};
        w_qbit    = (w_shift >= {1'b0, r_opnd2});
        w_hi_nxt  = r_hi;
        w_lo_nxt  = r_lo;
        w_rem_nxt = r_rem;
        if (r_op) begin
            // A kept difference is always below the divisor, so WIDTH bits hold it;
            // for a zero divisor the dropped MSB is the dividend bit shifted out.
            w_rem_nxt = w_qbit ? WIDTH'(w_shift - {1'b0, r_opnd2}) : w_shift[WIDTH-1:0];
            w_lo_nxt  = {r_lo[WIDTH-2:0], w_qbit};
        end else begin
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= IDLE;
            r_count <= '0;
            r_op    <= 1'b0;
            r_opnd2 <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_rem   <= '0;
            Result1 <= '0;
            Result2 <= '0;
            Done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            Done    <= w_last;
            if (w_accept) begin
                r_op    <= MCycleOp;
                r_opnd2 <= Operand2;
                r_lo    <= Operand1;
                r_hi    <= '0;
                r_rem   <= '0;
                r_count <= '0;
            end else if (r_state == COMPUTING) begin
                r_count <= r_count + CW'(1);
                r_hi    <= w_hi_nxt;
                r_lo    <= w_lo_nxt;
                r_rem   <= w_rem_nxt;
            end
            if (w_last) begin
                Result1 <= w_lo_nxt;
                Result2 <= r_op ? w_rem_nxt : w_hi_nxt;
            end
        end
    end

endmodule
